// File: rtl/col_fetch_scheduler.sv
// Row-command fetch scheduler: issues one read per column, tracks beat counts, tags last beats.
// Optional COL_FETCH_STATS_EN adds stat_rows / stat_stall counters.
module col_fetch_scheduler #(
  parameter int COL_COUNT       = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int MEMORY_WIDTH    = 512,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [COL_COUNT*ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]            cmd_len,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic [LEN_WIDTH-1:0]            rd_beats,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  input  logic [MEMORY_WIDTH-1:0]         rsp_data,
  input  logic                            rsp_valid,
  output logic                            rsp_ready,
  output logic [MEMORY_WIDTH-1:0]         out_data,
  output logic                            out_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            row_done,
  output logic                            busy
`ifdef COL_FETCH_STATS_EN
  ,
  output logic [31:0]                     stat_rows,
  output logic [31:0]                     stat_stall
`endif
);
  localparam int BYTES = MEMORY_WIDTH / 8;
  localparam int DEPTH = COL_COUNT * MAX_OUTSTANDING;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam int CW    = (COL_COUNT > 1) ? $clog2(COL_COUNT) : 1;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [LEN_WIDTH-1:0] BYTES_L = LEN_WIDTH'(BYTES);

  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nxt;

  logic [COL_COUNT-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]                 beats_q, beats_calc, head, beat_cnt;
  logic [CW-1:0]                        col_idx;
  logic [OW-1:0]                        outstanding;
  logic [LEN_WIDTH-1:0]                 fifo_mem [DEPTH];
  logic [PW-1:0]                        wr_ptr, rd_ptr;
  logic [CNTW-1:0]                      fifo_cnt;
  logic accept, rd_fire, out_fire, pop, fifo_empty, credit_ret, last_col;

  assign beats_calc = cmd_len / BYTES_L + LEN_WIDTH'(cmd_len % BYTES_L != '0);
  assign last_col   = (col_idx == CW'(COL_COUNT - 1));
  assign accept     = cmd_valid & cmd_ready & (cmd_len != '0);
  assign rd_fire    = rd_valid & rd_ready;
  assign credit_ret = row_done & (outstanding != '0);
  assign rd_addr    = addr_q[col_idx];
  assign rd_beats   = beats_q;
  assign busy       = (state != IDLE) | (outstanding != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rd_valid  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = (outstanding < OW'(MAX_OUTSTANDING));
        if (cmd_valid && cmd_ready && cmd_len != '0) state_nxt = ISSUE;
      end
      ISSUE: begin
        rd_valid = 1'b1;
        if (rd_ready && last_col) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // command registers and beat FIFO storage need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= cmd_addr;
      beats_q <= beats_calc;
    end
    if (rd_fire) fifo_mem[wr_ptr] <= rd_beats;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_idx     <= '0;
      outstanding <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      beat_cnt    <= '0;
    end else begin
      if (accept)       col_idx <= '0;
      else if (rd_fire) col_idx <= last_col ? '0 : col_idx + 1'b1;
      if (accept && !credit_ret)      outstanding <= outstanding + 1'b1;
      else if (!accept && credit_ret) outstanding <= outstanding - 1'b1;
      if (rd_fire) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CNTW'(rd_fire) - CNTW'(pop);
      if (pop)           beat_cnt <= '0;
      else if (out_fire) beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // responses stall whenever no issued request is pending in the FIFO
  assign fifo_empty = (fifo_cnt == '0);
  assign head       = fifo_mem[rd_ptr];
  assign out_data   = rsp_data;
  assign out_valid  = rsp_valid & ~fifo_empty;
  assign rsp_ready  = out_ready & ~fifo_empty;
  assign out_last   = ~fifo_empty & (beat_cnt == head - 1'b1);
  assign out_fire   = out_valid & out_ready;
  assign pop        = out_fire & out_last;

`ifdef COL_FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rows  <= '0;
      stat_stall <= '0;
    end else begin
      if (accept)                 stat_rows  <= stat_rows + 1'b1;
      if (cmd_valid && !cmd_ready) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_col_fetch_scheduler.sv
// Scoreboard bench for col_fetch_scheduler: expected reads/beats queued at command time.
module tb_col_fetch_scheduler;
  logic         clk = 1'b0;
  logic         rst;
  logic [95:0]  cmd_addr;
  logic [15:0]  cmd_len;
  logic         cmd_valid, cmd_ready;
  logic [31:0]  rd_addr;
  logic [15:0]  rd_beats;
  logic         rd_valid, rd_ready;
  logic [511:0] rsp_data;
  logic         rsp_valid, rsp_ready;
  logic [511:0] out_data;
  logic         out_last, out_valid, out_ready;
  logic         row_done, busy;

  typedef struct {logic [31:0] addr; logic [15:0] beats;} rd_t;
  typedef struct {logic [511:0] data; logic last;} out_t;
  rd_t  exp_rd_q[$];
  rd_t  mem_q[$];
  out_t exp_out_q[$];
  int   checks = 0, passes = 0, mem_beat = 0;
  bit   mem_en = 1'b1, bp_en = 1'b1;

  col_fetch_scheduler dut (
    .clk(clk), .rst(rst), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .rd_addr(rd_addr),
    .rd_beats(rd_beats), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .row_done(row_done), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [511:0] beat_data(input logic [31:0] a, input int b);
    logic [511:0] d;
    d = '0;
    d[31:0]    = b;
    d[63:32]   = a;
    d[511:480] = ~a;
    return d;
  endfunction

  // handshake monitor: scoreboard checks plus the memory model's request tracking
  always @(posedge clk) begin
    if (!rst) begin
      if (rd_valid && rd_ready) begin : rd_chk
        rd_t e;
        checks++;
        if (exp_rd_q.size() == 0)
          $display("FAIL rd_unexpected got addr=%h beats=%0d expected none", rd_addr, rd_beats);
        else begin
          e = exp_rd_q.pop_front();
          if (rd_addr !== e.addr || rd_beats !== e.beats)
            $display("FAIL rd_req got addr=%h beats=%0d expected addr=%h beats=%0d", rd_addr, rd_beats, e.addr, e.beats);
          else passes++;
        end
        mem_q.push_back('{rd_addr, rd_beats});
      end
      if (out_valid && out_ready) begin : out_chk
        out_t e;
        checks++;
        if (exp_out_q.size() == 0)
          $display("FAIL out_unexpected got data=%h last=%b expected none", out_data[63:0], out_last);
        else begin
          e = exp_out_q.pop_front();
          if (out_data !== e.data || out_last !== e.last)
            $display("FAIL out_beat got data=%h last=%b expected data=%h last=%b", out_data[63:0], out_last, e.data[63:0], e.last);
          else passes++;
        end
      end
      if (rsp_valid && rsp_ready && mem_q.size() > 0) begin
        mem_beat++;
        if (mem_beat == int'(mem_q[0].beats)) begin
          mem_q.delete(0);
          mem_beat = 0;
        end
      end
    end
  end

  // memory responder with random response gaps and output backpressure
  initial forever begin
    @(negedge clk);
    if (mem_en) begin
      if (mem_q.size() > 0 && (!bp_en || $urandom_range(0, 3) != 0)) begin
        rsp_valid = 1'b1;
        rsp_data  = beat_data(mem_q[0].addr, mem_beat);
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
      end
      out_ready = !bp_en || ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic push_exp(input logic [31:0] a0, a1, a2, input logic [15:0] len);
    logic [31:0] a [3];
    int nb;
    a = '{a0, a1, a2};
    nb = (int'(len) + 63) / 64;
    if (len != 0)
      for (int c = 0; c < 3; c++) begin
        exp_rd_q.push_back('{a[c], 16'(nb)});
        for (int b = 0; b < nb; b++) exp_out_q.push_back('{beat_data(a[c], b), b == nb - 1});
      end
  endtask

  task automatic send_cmd(input logic [31:0] a0, a1, a2, input logic [15:0] len,
                          input bit with_done, output bit ok);
    cmd_addr  = {a2, a1, a0};
    cmd_len   = len;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      push_exp(a0, a1, a2, len);
      row_done = with_done;
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    row_done  = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_rd_q.size() == 0 && exp_out_q.size() == 0 && mem_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_done();
    row_done = 1'b1;
    @(negedge clk);
    row_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_addr = '0; row_done = 1'b0;
    rd_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); else passes++;
    checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); else passes++;
    checks++; if (rsp_ready !== 1'b0) $display("FAIL reset_rsp_ready got=%b exp=0", rsp_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got=%b exp=0", out_last); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
  endtask

  task automatic test_single_row();
    bit ok;
    send_cmd(32'h1000, 32'h2000, 32'h3000, 16'd100, 1'b0, ok);
    checks++; if (!ok) $display("FAIL single_accept got=timeout exp=accepted"); else passes++;
    drain(ok);
    checks++; if (!ok) $display("FAIL single_drain got=pending exp=empty"); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL single_busy_held got=%b exp=1", busy); else passes++;
    pulse_done();
    checks++; if (busy !== 1'b0) $display("FAIL single_busy_done got=%b exp=0", busy); else passes++;
  endtask

  task automatic test_lengths();
    bit ok;
    int lens [4] = '{64, 128, 129, 1};
    foreach (lens[k]) begin
      send_cmd(32'h4000 + k * 32'h100, 32'h5000 + k * 32'h100, 32'h6000 + k * 32'h100, 16'(lens[k]), 1'b0, ok);
      drain(ok);
      checks++; if (!ok) $display("FAIL len_%0d_drain got=pending exp=empty", lens[k]); else passes++;
      pulse_done();
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    send_cmd(32'h7000, 32'h7100, 32'h7200, 16'd0, 1'b0, ok);
    checks++; if (!ok) $display("FAIL zero_accept got=timeout exp=accepted"); else passes++;
    checks++; if (rd_valid !== 1'b0) $display("FAIL zero_rd_valid got=%b exp=0", rd_valid); else passes++;
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL zero_idle got busy=%b ready=%b exp busy=0 ready=1", busy, cmd_ready); else passes++;
  endtask

  task automatic test_back_to_back();
    bit ok, leak;
    for (int r = 0; r < 4; r++) begin
      send_cmd(32'h10000 + r * 32'h1000, 32'h10040 + r * 32'h1000, 32'h10080 + r * 32'h1000, 16'd64, 1'b0, ok);
      checks++; if (!ok) $display("FAIL b2b_accept_%0d got=timeout exp=accepted", r); else passes++;
    end
    cmd_addr = {32'h20080, 32'h20040, 32'h20000}; cmd_len = 16'd64; cmd_valid = 1'b1;
    leak = 1'b0;
    for (int i = 0; i < 400 && exp_rd_q.size() != 0; i++) begin
      leak |= cmd_ready;
      @(negedge clk);
    end
    repeat (5) begin leak |= cmd_ready; @(negedge clk); end
    checks++; if (leak) $display("FAIL b2b_fifth_blocked got=ready exp=not_ready"); else passes++;
    push_exp(32'h20000, 32'h20040, 32'h20080, 16'd64);
    pulse_done();
    checks++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_after_done got=%b exp=1", cmd_ready); else passes++;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (rd_valid !== 1'b1) $display("FAIL b2b_fifth_issue got=%b exp=1", rd_valid); else passes++;
    drain(ok);
    checks++; if (!ok) $display("FAIL b2b_drain got=pending exp=empty"); else passes++;
    repeat (4) pulse_done();
    checks++; if (busy !== 1'b0) $display("FAIL b2b_busy got=%b exp=0", busy); else passes++;
  endtask

  task automatic test_rd_stall();
    bit ok, stable, nopush;
    rd_ready = 1'b0;
    send_cmd(32'h5000, 32'h6000, 32'h7000, 16'd200, 1'b0, ok);
    stable = 1'b1; nopush = 1'b1;
    repeat (10) begin
      stable &= (rd_valid === 1'b1) && (rd_addr === 32'h5000) && (rd_beats === 16'd4);
      nopush &= (rsp_ready === 1'b0) && (out_valid === 1'b0);
      @(negedge clk);
    end
    checks++; if (!stable) $display("FAIL stall_stable got addr=%h beats=%0d exp addr=5000 beats=4", rd_addr, rd_beats); else passes++;
    checks++; if (!nopush) $display("FAIL stall_no_push got rsp_ready=%b exp=0", rsp_ready); else passes++;
    rd_ready = 1'b1;
    drain(ok);
    checks++; if (!ok) $display("FAIL stall_drain got=pending exp=empty"); else passes++;
    pulse_done();
  endtask

  task automatic test_coincident();
    bit ok, all;
    all = 1'b1;
    for (int r = 0; r < 5; r++) begin
      send_cmd(32'h30000 + r * 32'h1000, 32'h30100 + r * 32'h1000, 32'h30200 + r * 32'h1000, 16'd64, r == 2, ok);
      all &= ok;
    end
    checks++; if (!all) $display("FAIL coinc_accepts got=blocked exp=all_five"); else passes++;
    drain(ok);
    checks++; if (cmd_ready !== 1'b0) $display("FAIL coinc_full got=%b exp=0", cmd_ready); else passes++;
    repeat (4) pulse_done();
    pulse_done();
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL coinc_underflow got busy=%b ready=%b exp busy=0 ready=1", busy, cmd_ready); else passes++;
  endtask

  task automatic test_reset_mid();
    bit ok, stalled;
    mem_en = 1'b0; rsp_valid = 1'b0; out_ready = 1'b1; rd_ready = 1'b0;
    send_cmd(32'h8000, 32'h9000, 32'hA000, 16'd100, 1'b0, ok);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL mid_cmd_ready got=%b exp=1", cmd_ready); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", busy); else passes++;
    checks++; if (rsp_ready !== 1'b0 || rd_valid !== 1'b0) $display("FAIL mid_rsp_rd got rsp_ready=%b rd_valid=%b exp 0 0", rsp_ready, rd_valid); else passes++;
    rst = 1'b0;
    exp_rd_q.delete(); exp_out_q.delete(); mem_q.delete(); mem_beat = 0;
    rsp_valid = 1'b1; rsp_data = beat_data(32'h8000, 0); rd_ready = 1'b1;
    stalled = 1'b1;
    repeat (3) begin @(negedge clk); stalled &= (rsp_ready === 1'b0) && (out_valid === 1'b0); end
    checks++; if (!stalled) $display("FAIL mid_stale_stall got rsp_ready=%b exp=0", rsp_ready); else passes++;
    rsp_valid = 1'b0; mem_en = 1'b1;
    send_cmd(32'hB000, 32'hC000, 32'hD000, 16'd100, 1'b0, ok);
    drain(ok);
    checks++; if (!ok) $display("FAIL mid_recover got=pending exp=empty"); else passes++;
    pulse_done();
    checks++; if (busy !== 1'b0) $display("FAIL mid_final_busy got=%b exp=0", busy); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_lengths();
    test_zero_len();
    test_back_to_back();
    test_rd_stall();
    test_coincident();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
